lif_step_scheduler: RTL

- Time-multiplexes one shared LIF update datapath across N_NEURONS neurons, holding every membrane potential in an internal register file.
- On each `start` pulse it runs one simulation timestep. For each neuron in index order it fetches the input current over a req/valid handshake, applies leak, integrate, threshold and reset, and writes the new potential back.
- Each spike is emitted as a valid/ready event carrying the neuron index.
- Sits between the spike-routing/weight-accumulation logic (current source) and the spike output fabric.

---
 rtl/lif_pkg.sv | 26 ++
 rtl/lif_update_unit.sv | 29 ++
 rtl/lif_step_scheduler.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared types, constants and saturating add for the LIF step scheduler
package lif_pkg;

  localparam int unsigned LIF_DATA_W = 16;
  // Leak factor is Q0.16: the leak term is the product shifted right by this amount
  localparam int unsigned LEAK_SHIFT = 16;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    UPDATE,
    EMIT,
    DONE
  } lif_state_e;

  // Widen by one bit, add, and clamp to the largest w-bit unsigned value
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] max_v;
    sum   = {1'b0, a} + {1'b0, b};
    max_v = (33'd1 << w) - 33'd1;
    return (sum > max_v) ? max_v[31:0] : sum[31:0];
  endfunction

endpackage

// File: rtl/lif_update_unit.sv
// rtl/lif_update_unit.sv - combinational leak/integrate/threshold/reset datapath for one neuron
module lif_update_unit
  import lif_pkg::*;
#(
  parameter int DATA_W = LIF_DATA_W
) (
  input  logic [DATA_W-1:0] v_i,
  input  logic [DATA_W-1:0] cur_i,
  input  logic [DATA_W-1:0] leak_i,
  input  logic [DATA_W-1:0] thr_i,
  input  logic [DATA_W-1:0] rst_i,
  output logic [DATA_W-1:0] v_next_o,
  output logic              fire_o
);

  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   lk;
  logic [DATA_W-1:0]   v_sat;

  // lk never exceeds v, so v - lk cannot underflow
  always_comb begin
    prod     = {{DATA_W{1'b0}}, v_i} * {{DATA_W{1'b0}}, leak_i};
    lk       = DATA_W'(prod >> DATA_W);
    v_sat    = DATA_W'(sat_add(32'(v_i - lk), 32'(cur_i), DATA_W));
    fire_o   = (v_sat >= thr_i);
    v_next_o = fire_o ? rst_i : v_sat;
  end

endmodule

// File: rtl/lif_step_scheduler.sv
// rtl/lif_step_scheduler.sv - time-multiplexed LIF timestep scheduler over N_NEURONS neurons
// Optional refractory counters are enabled by defining LIF_REFRACTORY_EN.
module lif_step_scheduler
  import lif_pkg::*;
#(
  parameter  int N_NEURONS    = 4,
  parameter  int DATA_W       = LIF_DATA_W,
  parameter  int REFRAC_STEPS = 2,
  localparam int IDX_W        = $clog2(N_NEURONS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] leak_factor,
  input  logic [DATA_W-1:0] threshold,
  input  logic [DATA_W-1:0] reset_potential,
  output logic              cur_req,
  output logic [IDX_W-1:0]  cur_idx,
  input  logic              cur_valid,
  input  logic [DATA_W-1:0] input_current,
  output logic              spike_valid,
  output logic [IDX_W-1:0]  spike_idx,
  input  logic              spike_ready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       step_count,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_potential
);

  lif_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] cur_q;
  logic [DATA_W-1:0] leak_q, thr_q, rstp_q;
  logic [15:0]       step_q;
  logic [DATA_W-1:0] pot_q [N_NEURONS];

  logic [DATA_W-1:0] unit_v, upd_v;
  logic              unit_fire, upd_fire;
  logic              last_idx;

  assign last_idx     = (idx_q == IDX_W'(N_NEURONS - 1));
  assign step_count   = step_q;
  assign rd_potential = pot_q[rd_idx];

  lif_update_unit #(.DATA_W(DATA_W)) u_update (
    .v_i      (pot_q[idx_q]),
    .cur_i    (cur_q),
    .leak_i   (leak_q),
    .thr_i    (thr_q),
    .rst_i    (rstp_q),
    .v_next_o (unit_v),
    .fire_o   (unit_fire)
  );

`ifdef LIF_REFRACTORY_EN
  localparam int RC_W = $clog2(REFRAC_STEPS + 1);

  logic [RC_W-1:0] refrac_q [N_NEURONS];
  logic            refrac_active;

  // A refractory neuron keeps its potential; the fetched current is dropped
  assign refrac_active = (refrac_q[idx_q] != '0);
  assign upd_v         = refrac_active ? pot_q[idx_q] : unit_v;
  assign upd_fire      = !refrac_active && unit_fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) refrac_q[i] <= '0;
    end else if (state_q == UPDATE) begin
      if (refrac_active) refrac_q[idx_q] <= refrac_q[idx_q] - 1'b1;
      else if (unit_fire) refrac_q[idx_q] <= RC_W'(REFRAC_STEPS);
    end
  end
`else
  logic unused_refrac;
  assign unused_refrac = (REFRAC_STEPS != 0);
  assign upd_v         = unit_v;
  assign upd_fire      = unit_fire;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (cur_valid) state_d = UPDATE;
      UPDATE: begin
        if (upd_fire)      state_d = EMIT;
        else if (last_idx) state_d = DONE;
        else               state_d = FETCH;
      end
      EMIT:    if (spike_ready) state_d = last_idx ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cur_req     = (state_q == FETCH);
    cur_idx     = (state_q == FETCH) ? idx_q : '0;
    spike_valid = (state_q == EMIT);
    spike_idx   = (state_q == EMIT) ? idx_q : '0;
    busy        = (state_q == FETCH) || (state_q == UPDATE) || (state_q == EMIT);
    done        = (state_q == DONE);
  end

  // Config is shadowed at start so mid-step changes cannot disturb the running step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) pot_q[i] <= '0;
      idx_q  <= '0;
      cur_q  <= '0;
      leak_q <= '0;
      thr_q  <= '0;
      rstp_q <= '0;
      step_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            leak_q <= leak_factor;
            thr_q  <= threshold;
            rstp_q <= reset_potential;
            idx_q  <= '0;
          end
        end
        FETCH: begin
          if (cur_valid) cur_q <= input_current;
        end
        UPDATE: begin
          pot_q[idx_q] <= upd_v;
          if (!upd_fire && !last_idx) idx_q <= idx_q + 1'b1;
        end
        EMIT: begin
          if (spike_ready && !last_idx) idx_q <= idx_q + 1'b1;
        end
        DONE: step_q <= step_q + 16'd1;
        default: ;
      endcase
    end
  end

endmodule
